// File: rtl/issuediv_unit_pkg.sv
// Shared definitions for the divide execution unit: default widths,
// FSM state encoding and a counter-width helper.
// Optional build macro: ISSUEDIV_SIGNED_EN (two's-complement divide).
package issuediv_unit_pkg;

  localparam int unsigned W_DATA_DEF = 32;
  localparam int unsigned W_TAG_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } div_state_t;

  // Width of an iteration counter that must reach w-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(W_DATA_DEF);

endpackage

// File: rtl/issuediv_unit_div_restoring_step.sv
// One iteration of a radix-2 restoring divider: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module div_restoring_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         borrow;

  // Trial subtraction; the difference always fits in W bits when there is
  // no borrow because the incoming partial remainder is below the divisor.
  always_comb begin
    shifted = {rem_in, bit_in};
    borrow  = (shifted < {1'b0, divisor});
    diff    = shifted[W-1:0] - divisor;
    rem_out = borrow ? shifted[W-1:0] : diff;
    q_bit   = ~borrow;
  end

endmodule

// File: rtl/issuediv_unit.sv
// Non-pipelined multi-cycle integer divide unit between the divide issue
// queue and CDB arbitration. One op in flight; result held until granted.
// Optional build macro: ISSUEDIV_SIGNED_EN (two's-complement operands).
module issuediv_unit
  import issuediv_unit_pkg::*;
#(
  parameter int unsigned W_DATA = W_DATA_DEF,
  parameter int unsigned W_TAG  = W_TAG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issuediv_ready,
  input  logic [W_DATA-1:0] issuediv_rsdata,
  input  logic [W_DATA-1:0] issuediv_rtdata,
  input  logic [W_TAG-1:0]  issuediv_rdtag,
  output logic              issuediv_done,
  output logic              issuediv_busy,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [W_DATA-1:0] cdb_data,
  output logic [W_DATA-1:0] cdb_rem,
  output logic [W_TAG-1:0]  cdb_tag
);

  localparam int unsigned CW = cnt_width(W_DATA);
  localparam logic [CW-1:0] LAST = CW'(W_DATA - 1);

  div_state_t        state;
  logic [CW-1:0]     count;
  logic [W_DATA-1:0] dvd_q;
  logic [W_DATA-1:0] dvs_q;
  logic [W_DATA-1:0] rem_q;
  logic [W_TAG-1:0]  tag_q;

  logic [W_DATA-1:0] dvd_in;
  logic [W_DATA-1:0] dvs_in;
  logic [W_DATA-1:0] rem_nxt;
  logic              q_bit;
  logic [W_DATA-1:0] quo_nxt;
  logic [W_DATA-1:0] res_quo;
  logic [W_DATA-1:0] res_rem;

`ifdef ISSUEDIV_SIGNED_EN
  logic              neg_q;
  logic              neg_r;
  logic              dvz;
  logic [W_DATA-1:0] dvd_orig;
`endif

  div_restoring_step #(.W(W_DATA)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[W_DATA-1]),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign issuediv_done = (state == IDLE) && issuediv_ready;
  assign issuediv_busy = (state != IDLE);

  // The dividend register doubles as the quotient register: dividend bits
  // leave at the MSB while quotient bits enter at the LSB.
  assign quo_nxt = {dvd_q[W_DATA-2:0], q_bit};

  // Operand conditioning at accept and result fix-up at RESULT load.
  always_comb begin
    dvd_in  = issuediv_rsdata;
    dvs_in  = issuediv_rtdata;
    res_quo = quo_nxt;
    res_rem = rem_nxt;
`ifdef ISSUEDIV_SIGNED_EN
    if (issuediv_rsdata[W_DATA-1]) dvd_in = -issuediv_rsdata;
    if (issuediv_rtdata[W_DATA-1]) dvs_in = -issuediv_rtdata;
    if (dvz) begin
      res_quo = '1;
      res_rem = dvd_orig;
    end else begin
      if (neg_q) res_quo = -quo_nxt;
      if (neg_r) res_rem = -rem_nxt;
    end
`endif
  end

  // Control FSM, iteration datapath and registered CDB outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      tag_q    <= '0;
      cdb_req  <= 1'b0;
      cdb_data <= '0;
      cdb_rem  <= '0;
      cdb_tag  <= '0;
`ifdef ISSUEDIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvz      <= 1'b0;
      dvd_orig <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issuediv_ready) begin
            dvd_q <= dvd_in;
            dvs_q <= dvs_in;
            tag_q <= issuediv_rdtag;
            rem_q <= '0;
            count <= '0;
            state <= CALC;
`ifdef ISSUEDIV_SIGNED_EN
            neg_q    <= issuediv_rsdata[W_DATA-1] ^ issuediv_rtdata[W_DATA-1];
            neg_r    <= issuediv_rsdata[W_DATA-1];
            dvz      <= (issuediv_rtdata == '0);
            dvd_orig <= issuediv_rsdata;
`endif
          end
        end
        CALC: begin
          dvd_q <= quo_nxt;
          rem_q <= rem_nxt;
          count <= count + CW'(1);
          if (count == LAST) begin
            state    <= RESULT;
            cdb_req  <= 1'b1;
            cdb_data <= res_quo;
            cdb_rem  <= res_rem;
            cdb_tag  <= tag_q;
          end
        end
        RESULT: begin
          if (cdb_grant) begin
            state   <= IDLE;
            cdb_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issuediv_unit.sv
// Scoreboard bench for issuediv_unit: the driver pushes hand-computed
// results, the monitor pops and compares on every granted CDB request.
module tb_issuediv_unit;

  logic        clk;
  logic        reset;
  logic        issuediv_ready;
  logic [31:0] issuediv_rsdata;
  logic [31:0] issuediv_rtdata;
  logic [5:0]  issuediv_rdtag;
  logic        issuediv_done;
  logic        issuediv_busy;
  logic        cdb_req;
  logic        cdb_grant;
  logic [31:0] cdb_data;
  logic [31:0] cdb_rem;
  logic [5:0]  cdb_tag;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [5:0]  t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef ISSUEDIV_SIGNED_EN
  localparam logic [31:0] Q_M7 = 32'hFFFFFFFD;
  localparam logic [31:0] R_M7 = 32'hFFFFFFFF;
  localparam logic [31:0] Q_MN = 32'h80000000;
  localparam logic [31:0] R_MN = 32'h00000000;
`else
  localparam logic [31:0] Q_M7 = 32'h7FFFFFFC;
  localparam logic [31:0] R_M7 = 32'h00000001;
  localparam logic [31:0] Q_MN = 32'h00000000;
  localparam logic [31:0] R_MN = 32'h80000000;
`endif

  issuediv_unit #(.W_DATA(32), .W_TAG(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .issuediv_ready  (issuediv_ready),
    .issuediv_rsdata (issuediv_rsdata),
    .issuediv_rtdata (issuediv_rtdata),
    .issuediv_rdtag  (issuediv_rdtag),
    .issuediv_done   (issuediv_done),
    .issuediv_busy   (issuediv_busy),
    .cdb_req         (cdb_req),
    .cdb_grant       (cdb_grant),
    .cdb_data        (cdb_data),
    .cdb_rem         (cdb_rem),
    .cdb_tag         (cdb_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every consumed CDB result must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cdb_req && cdb_grant) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got unexpected result q=0x%08h r=0x%08h, expected none",
                   cdb_data, cdb_rem);
        end else begin
          e = sb.pop_front();
          check("cdb_data", cdb_data, e.q);
          check("cdb_rem", cdb_rem, e.r);
          check("cdb_tag", {26'd0, cdb_tag}, {26'd0, e.t});
        end
      end
    end
  end

  // Wait for cdb_req counting cycles from an accept edge (called at edge+#1).
  task automatic wait_req(input string name);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!cdb_req) check({name, "_done_low"}, {31'd0, issuediv_done}, 32'd0);
    end while (!cdb_req && lat < 100);
    check({name, "_latency"}, lat, 33);
  endtask

  // Issue one op with grant held high, called at posedge+#1 with unit idle.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t, input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    issuediv_rsdata = a;
    issuediv_rtdata = b;
    issuediv_rdtag  = t;
    issuediv_ready  = 1'b1;
    @(negedge clk);
    check({name, "_done"}, {31'd0, issuediv_done}, 32'd1);
    e.q = q; e.r = r; e.t = t;
    sb.push_back(e);
    @(posedge clk); #1;
    issuediv_ready  = 1'b0;
    issuediv_rsdata = $urandom;
    issuediv_rtdata = $urandom;
    issuediv_rdtag  = 6'h3F;
    wait_req(name);
    @(posedge clk); #1;
    check({name, "_busy_after"}, {31'd0, issuediv_busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset           = 1'b0;
    issuediv_ready  = 1'b0;
    issuediv_rsdata = '0;
    issuediv_rtdata = '0;
    issuediv_rdtag  = '0;
    cdb_grant       = 1'b1;
    #2;
    check("rst_req", {31'd0, cdb_req}, 32'd0);
    check("rst_data", cdb_data, 32'd0);
    check("rst_rem", cdb_rem, 32'd0);
    check("rst_tag", {26'd0, cdb_tag}, 32'd0);
    check("rst_busy", {31'd0, issuediv_busy}, 32'd0);
    check("rst_done", {31'd0, issuediv_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("basic", 32'd100, 32'd7, 6'h15, 32'd14, 32'd2);
    run_op("div0", 32'h1234, 32'd0, 6'h01, 32'hFFFFFFFF, 32'h1234);
    run_op("max_by1", 32'hFFFFFFFF, 32'd1, 6'h02, 32'hFFFFFFFF, 32'd0);
    run_op("small", 32'd5, 32'd9, 6'h03, 32'd0, 32'd5);
    run_op("m7_by2", 32'hFFFFFFF9, 32'd2, 6'h04, Q_M7, R_M7);
    run_op("mn_bym1", 32'h80000000, 32'hFFFFFFFF, 6'h05, Q_MN, R_MN);

    // Back-pressure: grant withheld while a second op is ready throughout.
    cdb_grant       = 1'b0;
    issuediv_rsdata = 32'd77;
    issuediv_rtdata = 32'd4;
    issuediv_rdtag  = 6'h2A;
    issuediv_ready  = 1'b1;
    @(negedge clk);
    check("bp1_done", {31'd0, issuediv_done}, 32'd1);
    e.q = 32'd19; e.r = 32'd1; e.t = 6'h2A;
    sb.push_back(e);
    @(posedge clk); #1;
    issuediv_rsdata = 32'd50;
    issuediv_rtdata = 32'd5;
    issuediv_rdtag  = 6'h07;
    wait_req("bp1");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_req", {31'd0, cdb_req}, 32'd1);
      check("bp_hold_data", cdb_data, 32'd19);
      check("bp_hold_rem", cdb_rem, 32'd1);
      check("bp_hold_tag", {26'd0, cdb_tag}, 32'h2A);
      check("bp_hold_done", {31'd0, issuediv_done}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    cdb_grant = 1'b1;
    @(negedge clk);
    check("bp_grant_done", {31'd0, issuediv_done}, 32'd0);
    e.q = 32'd10; e.r = 32'd0; e.t = 6'h07;
    sb.push_back(e);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp2_done", {31'd0, issuediv_done}, 32'd1);
    @(posedge clk); #1;
    issuediv_ready  = 1'b0;
    issuediv_rsdata = 32'hDEADBEEF;
    issuediv_rtdata = 32'h1;
    wait_req("bp2");
    @(posedge clk); #1;

    // Reset in the middle of a calculation discards the op.
    issuediv_rsdata = 32'd1000;
    issuediv_rtdata = 32'd3;
    issuediv_rdtag  = 6'h11;
    issuediv_ready  = 1'b1;
    @(negedge clk);
    check("rc_done", {31'd0, issuediv_done}, 32'd1);
    @(posedge clk); #1;
    issuediv_ready = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rc_busy_before", {31'd0, issuediv_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rc_req", {31'd0, cdb_req}, 32'd0);
    check("rc_data", cdb_data, 32'd0);
    check("rc_rem", cdb_rem, 32'd0);
    check("rc_tag", {26'd0, cdb_tag}, 32'd0);
    check("rc_busy", {31'd0, issuediv_busy}, 32'd0);
    check("rc_done0", {31'd0, issuediv_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 32'd9, 32'd4, 6'h09, 32'd2, 32'd1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
